node_tx_port: RTL and testbench

//   Node-side transmitter feeding one router input port. It queues packets

---
 rtl/node_tx_port_pkg.sv | 26 ++
 rtl/node_tx_port_fifo.sv | 67 ++++++
 rtl/node_tx_port.sv | 122 ++++++++++++
 tb/tb_node_tx_port.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/node_tx_port_pkg.sv
// Shared types for the node-side router transmitter: packet format,
// node addressing and the transmit handshake states.
package RouterPkg;

    localparam int NODE_MAX = 5;

    typedef logic [2:0] node_t;

    typedef struct packed {
        node_t      dest;
        node_t      src;
        logic [7:0] payload;
    } pkt_t;

    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        ACK,
        DROP
    } tx_state_t;

    function automatic logic dest_ok(input pkt_t p);
        return p.dest <= node_t'(NODE_MAX);
    endfunction

endpackage

// File: rtl/node_tx_port_fifo.sv
// Small packet FIFO with single-cycle push/pop and a combinational head.
// Storage is not reset; only pointers and occupancy are.
module pkt_fifo
    import RouterPkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push_i,
    input  pkt_t                       push_data_i,
    input  logic                       pop_i,
    output pkt_t                       head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    pkt_t          mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/node_tx_port.sv
// Node-side transmitter: queues local packets and offers the FIFO head to a
// router input port with a four-phase routed handshake, timeout and counters.
module node_tx_port
    import RouterPkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  pkt_t                       pkt_in,
    input  logic                       pkt_valid_in,
    output logic                       pkt_ready_out,
    output pkt_t                       data_out,
    output logic                       data_ready_out,
    input  logic                       data_routed_in,
    output logic [$clog2(DEPTH+1)-1:0] count_out,
    output logic [CNT_W-1:0]           sent_count,
    output logic                       err_bad_dest,
    output logic                       err_timeout
);

    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0]    T_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0]    T_ONE   = TW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    tx_state_t        state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    pkt_t             data_q, data_d;
    logic [CNT_W-1:0] sent_q, sent_d;
    logic             bad_q, bad_d;
    logic             to_q, to_d;
    logic             avail_q;

    logic accept, push, pop, full, empty;
    pkt_t head;

    assign accept = pkt_valid_in && !full;
    assign push   = accept && dest_ok(pkt_in);
    assign bad_d  = accept && !dest_ok(pkt_in);

    pkt_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (pkt_in),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count_out),
        .full_o      (full),
        .empty_o     (empty)
    );

    // The head must have been present for a full cycle (avail_q) before it is
    // offered, giving a two-edge push-to-offer latency.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        data_d  = data_q;
        sent_d  = sent_q;
        to_d    = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (avail_q && !empty && !data_routed_in) begin
                    state_d = OFFER;
                    data_d  = head;
                    timer_d = '0;
                end
            end
            OFFER: begin
                timer_d = timer_q + T_ONE;
                if (data_routed_in) begin
                    state_d = ACK;
                    pop     = 1'b1;
                    sent_d  = sent_q + CNT_ONE;
                    data_d  = '0;
                end else if (timer_q == T_LAST) begin
                    state_d = DROP;
                    pop     = 1'b1;
                    to_d    = 1'b1;
                    data_d  = '0;
                end
            end
            ACK: begin
                if (!data_routed_in) state_d = IDLE;
            end
            DROP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            data_q  <= '0;
            sent_q  <= '0;
            bad_q   <= 1'b0;
            to_q    <= 1'b0;
            avail_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            data_q  <= data_d;
            sent_q  <= sent_d;
            bad_q   <= bad_d;
            to_q    <= to_d;
            avail_q <= !empty;
        end
    end

    assign pkt_ready_out  = !full;
    assign data_out       = data_q;
    assign data_ready_out = (state_q == OFFER);
    assign sent_count     = sent_q;
    assign err_bad_dest   = bad_q;
    assign err_timeout    = to_q;

endmodule

// File: tb/tb_node_tx_port.sv
// Randomized bench for node_tx_port against a transaction-timing reference
// model built from the packet queue and offer/ack/drop timing rules.
module tb_node_tx_port;
    import RouterPkg::*;

    localparam int DEPTH = 4;
    localparam int TOUT  = 8;
    localparam int CNT_W = 16;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    pkt_t             pkt_in = '0;
    logic             pkt_valid_in = 1'b0;
    logic             pkt_ready_out;
    pkt_t             data_out;
    logic             data_ready_out;
    logic             data_routed_in = 1'b0;
    logic [2:0]       count_out;
    logic [CNT_W-1:0] sent_count;
    logic             err_bad_dest;
    logic             err_timeout;

    node_tx_port #(.DEPTH(DEPTH), .TIMEOUT_CYC(TOUT), .CNT_W(CNT_W)) dut (
        .clock          (clock),
        .reset          (reset),
        .pkt_in         (pkt_in),
        .pkt_valid_in   (pkt_valid_in),
        .pkt_ready_out  (pkt_ready_out),
        .data_out       (data_out),
        .data_ready_out (data_ready_out),
        .data_routed_in (data_routed_in),
        .count_out      (count_out),
        .sent_count     (sent_count),
        .err_bad_dest   (err_bad_dest),
        .err_timeout    (err_timeout)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: queue of stored packets plus offer timing bookkeeping.
    pkt_t             mq[$];
    bit               m_off;
    pkt_t             m_data;
    int               m_len;
    bit               m_ackw;
    int               m_next;
    bit               m_ne_prev;
    logic [CNT_W-1:0] m_sent;
    bit               m_bad, m_to;
    int               t = 0;

    task automatic model_reset();
        mq.delete();
        m_off = 0; m_data = '0; m_len = 0; m_ackw = 0; m_next = t;
        m_ne_prev = 0; m_sent = '0; m_bad = 0; m_to = 0;
    endtask

    task automatic model_update(input bit v, input pkt_t p, input bit r);
        bit ne_now, do_pop, do_push, nb, nt;
        ne_now = (mq.size() != 0);
        do_pop = 0; do_push = 0; nb = 0; nt = 0;
        if (m_off) begin
            m_len++;
            if (r) begin
                do_pop = 1; m_sent = m_sent + 1'b1; m_off = 0; m_ackw = 1;
            end else if (m_len == TOUT) begin
                do_pop = 1; nt = 1; m_off = 0; m_next = t + 2;
            end
        end else if (m_ackw) begin
            if (!r) begin m_ackw = 0; m_next = t + 1; end
        end else if (t >= m_next && ne_now && m_ne_prev && !r) begin
            m_off = 1; m_data = mq[0]; m_len = 0;
        end
        if (v && mq.size() < DEPTH) begin
            if (p.dest > NODE_MAX) nb = 1;
            else do_push = 1;
        end
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back(p);
        m_ne_prev = ne_now;
        m_bad = nb;
        m_to = nt;
        t++;
    endtask

    task automatic check_outputs();
        check_eq("data_ready_out", 32'(data_ready_out), 32'(m_off));
        check_eq("data_out", 32'(data_out), 32'(m_off ? m_data : pkt_t'(0)));
        check_eq("count_out", 32'(count_out), 32'(mq.size()));
        check_eq("pkt_ready_out", 32'(pkt_ready_out), 32'(mq.size() < DEPTH));
        check_eq("sent_count", 32'(sent_count), 32'(m_sent));
        check_eq("err_bad_dest", 32'(err_bad_dest), 32'(m_bad));
        check_eq("err_timeout", 32'(err_timeout), 32'(m_to));
    endtask

    // Called at a falling edge: check, drive the next cycle, advance the model.
    task automatic step(input bit v, input pkt_t p, input bit r);
        check_outputs();
        pkt_valid_in   = v;
        pkt_in         = p;
        data_routed_in = r;
        model_update(v, p, r);
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) step(1'b0, pkt_t'(0), r);
    endtask

    task automatic apply_reset();
        pkt_valid_in = 1'b0; pkt_in = '0; data_routed_in = 1'b0;
        reset = 1'b1;
        #1;
        check_eq("rst_ready_out", 32'(data_ready_out), 32'd0);
        check_eq("rst_count_out", 32'(count_out), 32'd0);
        check_eq("rst_sent_count", 32'(sent_count), 32'd0);
        check_eq("rst_pkt_ready", 32'(pkt_ready_out), 32'd1);
        check_eq("rst_data_out", 32'(data_out), 32'd0);
        check_eq("rst_errs", 32'({err_bad_dest, err_timeout}), 32'd0);
        model_reset();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    function automatic pkt_t mk(input int d, input int pl);
        pkt_t p;
        p.dest    = node_t'(d);
        p.src     = node_t'($urandom_range(0, 7));
        p.payload = 8'(pl);
        return p;
    endfunction

    task automatic basic_send();
        step(1'b1, mk(2, 8'hA5), 1'b0);
        idle(5, 1'b0);
        check_eq("t1_offer_up", 32'(data_ready_out), 32'd1);
        step(1'b0, pkt_t'(0), 1'b1);
        idle(3, 1'b0);
        check_eq("t1_sent", 32'(sent_count), 32'd1);
    endtask

    initial begin
        @(negedge clock);
        apply_reset();

        basic_send();

        // Fill to DEPTH, a fifth push must be refused; then drain in order.
        for (int i = 0; i < 5; i++) step(1'b1, mk($urandom_range(0, NODE_MAX), 8'h10 + i), 1'b0);
        check_eq("t2_full", 32'(pkt_ready_out), 32'd0);
        for (int i = 0; i < 60; i++) step(1'b0, pkt_t'(0), 1'($urandom_range(0, 1)));

        step(1'b1, mk(7, 8'h77), 1'b0);
        idle(3, 1'b0);

        // Two timeouts, then an ack landing on the final allowed cycle.
        step(1'b1, mk(1, 8'h31), 1'b0);
        step(1'b1, mk(3, 8'h32), 1'b0);
        idle(30, 1'b0);
        step(1'b1, mk(4, 8'h41), 1'b0);
        for (int i = 0; i < 20 && !(m_off && m_len == TOUT - 1); i++) step(1'b0, pkt_t'(0), 1'b0);
        check_eq("t4_last_cycle", 32'(data_ready_out), 32'd1);
        step(1'b0, pkt_t'(0), 1'b1);
        idle(3, 1'b0);

        // Routed held high after an ack blocks the next offer.
        step(1'b1, mk(5, 8'h51), 1'b0);
        step(1'b1, mk(0, 8'h52), 1'b0);
        for (int i = 0; i < 10 && !m_off; i++) step(1'b0, pkt_t'(0), 1'b0);
        check_eq("t5_offer_up", 32'(data_ready_out), 32'd1);
        idle(6, 1'b1);
        idle(8, 1'b0);
        step(1'b0, pkt_t'(0), 1'b1);
        idle(3, 1'b0);

        // Reset in the middle of an offer.
        step(1'b1, mk(2, 8'h61), 1'b0);
        step(1'b1, mk(2, 8'h62), 1'b0);
        for (int i = 0; i < 10 && !m_off; i++) step(1'b0, pkt_t'(0), 1'b0);
        check_eq("t6_offer_up", 32'(data_ready_out), 32'd1);
        step(1'b0, pkt_t'(0), 1'b0);
        apply_reset();
        basic_send();

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 799) == 0) apply_reset();
            step(1'($urandom_range(0, 2) != 0),
                 mk($urandom_range(0, 7), $urandom_range(0, 255)),
                 1'($urandom_range(0, 3) == 0 || (data_routed_in && $urandom_range(0, 1) == 0)));
        end
        check_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
